ntsc_phase_detect: RTL and testbench

Colour-carrier phase detector for the NTSC video path: the decode counterpart of the carrier phase generator. It samples a 1-bit burst-phase square wave and a 1-bit colour-phase square wave, both with a 32-clock period. It measures how many clocks the colour wave lags the burst wave and reports that lag as a 5-bit phase-select value. The block is used for loopback self-test of the GPU colour encoder and for recovering palette phase from captured composite timing.

---
 rtl/ntsc_phase_detect.sv | 99 +++++++++
 tb/tb_ntsc_phase_detect.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ntsc_phase_detect.sv
// Colour-carrier phase detector: measures colour lag behind burst (0..31 clocks) and tracks lock.
// Latency 2 clocks from input edge to phase/phaseStrobe; free-running, no backpressure.
module ntsc_phase_detect #(
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       burstIn,
    input  logic       colorIn,
    output logic [4:0] phase,
    output logic       phaseStrobe,
    output logic       locked
);

    localparam logic [2:0] LC = LOCK_COUNT[2:0];
    localparam logic [7:0] TO = TIMEOUT[7:0];

    logic       r_b_s1, r_b_s2, r_c_s1, r_c_s2;
    logic [4:0] r_ts, r_bts, r_phase;
    logic       r_burst_seen, r_strobe, r_locked;
    logic [2:0] r_mc;
    logic [7:0] r_wd;

    logic       w_b_edge, w_c_edge, w_accept, w_timeout;
    logic [4:0] w_delta;
    logic [7:0] w_wd_inc;
    logic [2:0] w_mc_nxt;

    assign w_b_edge  = r_b_s1 & ~r_b_s2;
    assign w_c_edge  = r_c_s1 & ~r_c_s2;
    assign w_accept  = w_c_edge & (r_burst_seen | w_b_edge);
    // A same-cycle burst edge means the lag is zero, not a wrap of the stored timestamp.
    assign w_delta   = r_ts - (w_b_edge ? r_ts : r_bts);
    assign w_wd_inc  = (r_wd == 8'hFF) ? r_wd : r_wd + 8'd1;
    assign w_timeout = ~w_accept & (w_wd_inc == TO);

    always_comb begin
        w_mc_nxt = r_mc;
        if (w_accept) begin
            if ((r_mc == 3'd0) || (w_delta != r_phase)) begin
                w_mc_nxt = 3'd1;
            end else if (r_mc < LC) begin
                w_mc_nxt = r_mc + 3'd1;
            end
        end else if (w_timeout) begin
            w_mc_nxt = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_b_s1       <= 1'b0;
            r_b_s2       <= 1'b0;
            r_c_s1       <= 1'b0;
            r_c_s2       <= 1'b0;
            r_ts         <= 5'd0;
            r_bts        <= 5'd0;
            r_burst_seen <= 1'b0;
            r_phase      <= 5'd0;
            r_strobe     <= 1'b0;
            r_locked     <= 1'b0;
            r_mc         <= 3'd0;
            r_wd         <= 8'd0;
        end else begin
            r_b_s1   <= burstIn;
            r_b_s2   <= r_b_s1;
            r_c_s1   <= colorIn;
            r_c_s2   <= r_c_s1;
            r_ts     <= r_ts + 5'd1;
            r_strobe <= w_accept;
            r_mc     <= w_mc_nxt;
            r_locked <= (w_mc_nxt == LC);

            // A fresh burst edge outranks the watchdog discarding the old one.
            if (w_b_edge) begin
                r_bts        <= r_ts;
                r_burst_seen <= 1'b1;
            end else if (w_timeout) begin
                r_burst_seen <= 1'b0;
            end

            if (w_accept) begin
                r_phase <= w_delta;
            end

            if (w_accept || w_timeout) begin
                r_wd <= 8'd0;
            end else begin
                r_wd <= w_wd_inc;
            end
        end
    end

    assign phase       = r_phase;
    assign phaseStrobe = r_strobe;
    assign locked      = r_locked;

endmodule

// File: tb/tb_ntsc_phase_detect.sv
// Scoreboard bench for ntsc_phase_detect: directed lags with hand-derived strobe expectations.
module tb_ntsc_phase_detect;

    localparam int LOCK = 4;
    localparam int TO   = 63;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       burstIn = 1'b0;
    logic       colorIn = 1'b0;
    logic [4:0] phase;
    logic       phaseStrobe;
    logic       locked;

    always #5 clk = ~clk;

    ntsc_phase_detect #(.LOCK_COUNT(LOCK), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .burstIn    (burstIn),
        .colorIn    (colorIn),
        .phase      (phase),
        .phaseStrobe(phaseStrobe),
        .locked     (locked)
    );

    typedef struct packed {
        logic [4:0] ph;
        logic       lk;
        logic       gap;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_strobe_cyc = 0;
    int         n_strobes = 0;
    logic [4:0] t = 5'd0;
    int         lag = 0;
    int         mode = 0;   // 0 normal, 1 both low, 2 colour only

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Stimulus generator: burst = t[4], colour = (t - lag)[4]
    initial begin
        forever begin
            logic [4:0] tl;
            @(posedge clk);
            #1;
            if (reset) t = 5'd0;
            else       t = t + 5'd1;
            tl = t - lag[4:0];
            case (mode)
                1:       begin burstIn = 1'b0; colorIn = 1'b0;  end
                2:       begin burstIn = 1'b0; colorIn = t[4];  end
                default: begin burstIn = t[4]; colorIn = tl[4]; end
            endcase
        end
    end

    // Monitor: every strobe is matched against the next queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (phaseStrobe) begin
                int prev;
                exp_t e;
                prev = last_strobe_cyc;
                last_strobe_cyc = cyc;
                n_strobes++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe actual phase=%0d required=no strobe", phase);
                end else begin
                    e = q.pop_front();
                    check("strobe_phase", int'(phase), int'(e.ph));
                    check("strobe_locked", int'(locked), int'(e.lk));
                    if (e.gap) check("strobe_gap", cyc - prev, 32);
                end
            end
        end
    end

    task automatic push_seq(input int lg, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.ph  = lg[4:0];
            e.lk  = (i >= LOCK - 1);
            e.gap = (i > 0);
            q.push_back(e);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual pending=%0d required=0", name, q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic restart(input int lg, input int md);
        @(negedge clk);
        reset = 1'b1;
        lag   = lg;
        mode  = md;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int sc;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_phase", int'(phase), 0);
        check("rst_strobe", int'(phaseStrobe), 0);
        check("rst_locked", int'(locked), 0);

        // Steady lag 5: lock on the 4th strobe and stay locked
        lag = 5; mode = 0; reset = 1'b0;
        push_seq(5, 6);
        drain("lag5", 6 * 32 + 100);

        // Boundary lags
        restart(0, 0);
        push_seq(0, 5);
        drain("lag0", 5 * 32 + 100);

        restart(31, 0);
        push_seq(31, 5);
        drain("lag31", 5 * 32 + 150);

        // Phase step 12 -> 20, switched at t==0 so no spurious colour edge
        restart(12, 0);
        push_seq(12, 4);
        drain("lag12", 4 * 32 + 100);
        n = 0;
        while (t != 5'd0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        lag = 20;
        push_seq(20, 4);
        drain("lag20", 4 * 32 + 100);

        // Signal loss after locking at 7
        restart(7, 0);
        push_seq(7, 4);
        drain("lag7", 4 * 32 + 100);
        check("loss_pre_locked", int'(locked), 1);
        mode = 1;
        n = 0;
        while (locked && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("loss_unlock_delay", cyc - last_strobe_cyc, TO);
        check("loss_locked", int'(locked), 0);
        check("loss_phase", int'(phase), 7);
        sc = n_strobes;
        repeat (80) @(negedge clk);
        check("loss_no_strobes", n_strobes - sc, 0);
        check("loss_phase_hold", int'(phase), 7);

        // Colour only: never a strobe
        restart(0, 2);
        sc = n_strobes;
        repeat (160) @(negedge clk);
        check("colour_only_strobes", n_strobes - sc, 0);
        check("colour_only_phase", int'(phase), 0);
        check("colour_only_locked", int'(locked), 0);

        // Reset mid-lock at lag 9
        restart(9, 0);
        push_seq(9, 4);
        drain("lag9", 4 * 32 + 100);
        check("pre_rst_locked", int'(locked), 1);
        check("pre_rst_phase", int'(phase), 9);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_phase", int'(phase), 0);
        check("midrst_locked", int'(locked), 0);
        check("midrst_strobe", int'(phaseStrobe), 0);
        reset = 1'b0;
        push_seq(9, 5);
        drain("relock9", 5 * 32 + 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=expired required=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
